// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address_dmem;
  logic [DATA_W-1:0] data;
  logic              wren;
  logic              rden;
  logic              ready;
  logic [DATA_W-1:0] mem_content;
  logic              valid;
  logic              ack;

  modport master (
    output address_dmem, data, wren, rden,
    input  ready, mem_content, valid, ack
  );

  modport slave (
    input  address_dmem, data, wren, rden,
    output ready, mem_content, valid, ack
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches one request, waits
// WAIT_CYCLES, then commits the write or returns registered read data.
module dmem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]        state;
  logic [3:0]        count;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              write_q;
  logic [DATA_W-1:0] read_data;
  logic              valid_q;
  logic              ack_q;
  logic              accept;
  logic              finish_write;
  logic              finish_read;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // A simultaneous wren/rden is latched as a write, so the read is dropped.
  assign accept       = (state == IDLE) && (bus.wren || bus.rden);
  assign finish_write = (state == DONE) && write_q;
  assign finish_read  = (state == DONE) && !write_q;

  assign bus.ready       = (state == IDLE);
  assign bus.mem_content = read_data;
  assign bus.valid       = valid_q;
  assign bus.ack         = ack_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      count   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q  <= bus.address_dmem;
            data_q  <= bus.data;
            write_q <= bus.wren;
            count   <= WAIT_INIT;
            state   <= (WAIT_CYCLES > 0) ? WAIT : DONE;
          end
        end
        WAIT: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      read_data <= '0;
      valid_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      valid_q <= finish_read;
      ack_q   <= finish_write;
      if (finish_read) begin
        read_data <= mem[addr_q];
      end
    end
  end

  // Storage is deliberately not reset; an abandoned write never reaches DONE.
  always_ff @(posedge clock) begin
    if (finish_write) begin
      mem[addr_q] <= data_q;
    end
  end
endmodule
